// File: rtl/div_sequencer_pkg.sv
// Shared constants and state encoding for the multi-cycle divide sequencer.
// Imported by the sequencer top and its adder slice.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// Shared conditional-invert adder: sum/cout = a + (b ^ {invert}) + cin.
// Purely combinational; the sequencer decides per state how it is used.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_mod_s;

  assign b_mod_s     = b ^ {WIDTH{invert}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_mod_s} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/div_sequencer.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up before and after the loop, divide-by-zero short path.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_r, state_n_s;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dq_r;
  logic             signed_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             zero_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_zero_r;
  logic             done_r;
  logic             busy_r;

  logic [WIDTH:0]   add_a_s;
  logic [WIDTH:0]   add_b_s;
  logic             add_inv_s;
  logic             add_cin_s;
  logic [WIDTH:0]   add_sum_s;
  logic             add_cout_s;
  logic             unused_sum_msb_s;

  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic             dvs_zero_s;

  // Carry-free two's-complement negate: a bit flips once any lower bit was set.
  // Lets the divisor and quotient be negated without a second adder.
  function automatic logic [WIDTH-1:0] negate_prefix(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    logic             seen;
    seen = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[i] ^ seen;
      seen = seen | x[i];
    end
    return r;
  endfunction

  assign dvd_neg_s        = signed_r & dvd_r[WIDTH-1];
  assign dvs_neg_s        = signed_r & dvs_r[WIDTH-1];
  assign dvs_zero_s       = (dvs_r == {WIDTH{1'b0}});
  assign unused_sum_msb_s = add_sum_s[WIDTH];

  div_step #(
    .WIDTH (WIDTH + 1)
  ) u_step (
    .a      (add_a_s),
    .b      (add_b_s),
    .invert (add_inv_s),
    .cin    (add_cin_s),
    .sum    (add_sum_s),
    .cout   (add_cout_s)
  );

  // Adder operand select: negate dividend in PREP, trial subtract in ITER,
  // negate remainder in FIX. The extra top bit keeps 2*rem+1 from overflowing.
  always_comb begin
    add_a_s   = {(WIDTH+1){1'b0}};
    add_b_s   = {(WIDTH+1){1'b0}};
    add_inv_s = 1'b0;
    add_cin_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        add_inv_s = 1'b0;
        add_cin_s = 1'b0;
      end
      ST_PREP: begin
        add_inv_s = 1'b1;
        add_cin_s = 1'b1;
        add_b_s   = {1'b0, dvd_r};
      end
      ST_ITER: begin
        add_inv_s = 1'b1;
        add_cin_s = 1'b1;
        add_a_s   = {rem_r, dq_r[WIDTH-1]};
        add_b_s   = {1'b0, dvs_r};
      end
      ST_FIX: begin
        add_inv_s = 1'b1;
        add_cin_s = 1'b1;
        add_b_s   = {1'b0, rem_r};
      end
      default: begin
        add_inv_s = 1'b0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_n_s = ST_PREP;
        else       state_n_s = ST_IDLE;
      end
      ST_PREP: begin
        if (dvs_zero_s) state_n_s = ST_FIX;
        else            state_n_s = ST_ITER;
      end
      ST_ITER: begin
        if (count_r == {CNT_W{1'b0}}) state_n_s = ST_FIX;
        else                          state_n_s = ST_ITER;
      end
      ST_FIX:  state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State register and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      busy_r  <= (state_n_s != ST_IDLE);
      done_r  <= (state_r == ST_FIX);
    end
  end

  // Operand capture, sign pre-processing and the shift-subtract loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CNT_W{1'b0}};
      dvd_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      dq_r     <= {WIDTH{1'b0}};
      signed_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            dvd_r    <= dividend;
            dvs_r    <= divisor;
            signed_r <= is_signed;
            zero_r   <= 1'b0;
          end else begin
            zero_r   <= zero_r;
          end
        end
        ST_PREP: begin
          if (dvs_zero_s) begin
            zero_r <= 1'b1;
          end else begin
            dq_r    <= dvd_neg_s ? add_sum_s[WIDTH-1:0] : dvd_r;
            dvs_r   <= dvs_neg_s ? negate_prefix(dvs_r) : dvs_r;
            neg_q_r <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r <= dvd_neg_s;
            rem_r   <= {WIDTH{1'b0}};
            count_r <= CNT_W'(WIDTH - 1);
          end
        end
        ST_ITER: begin
          // Carry out means the shifted remainder was >= divisor: keep the difference.
          rem_r <= add_cout_s ? add_sum_s[WIDTH-1:0] : add_a_s[WIDTH-1:0];
          dq_r  <= {dq_r[WIDTH-2:0], add_cout_s};
          if (count_r != {CNT_W{1'b0}}) count_r <= count_r - CNT_W'(1);
          else                          count_r <= count_r;
        end
        ST_FIX: begin
          zero_r <= zero_r;
        end
        default: begin
          zero_r <= zero_r;
        end
      endcase
    end
  end

  // Result registers: only the FIX edge (or reset) updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      div_zero_r  <= 1'b0;
    end else if (state_r == ST_FIX) begin
      if (zero_r) begin
        quotient_r  <= {WIDTH{1'b1}};
        remainder_r <= dvd_r;
        div_zero_r  <= 1'b1;
      end else begin
        quotient_r  <= neg_q_r ? negate_prefix(dq_r) : dq_r;
        remainder_r <= neg_r_r ? add_sum_s[WIDTH-1:0] : rem_r;
        div_zero_r  <= 1'b0;
      end
    end else begin
      quotient_r  <= quotient_r;
      remainder_r <= remainder_r;
      div_zero_r  <= div_zero_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expectations are queued at START and
// compared when DONE pulses, including result latency.
module tb_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
    int          start_cyc;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   cyc        = 0;
  int   done_cnt   = 0;
  int   op_id      = 0;

  div_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure START-to-DONE latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Independent reference: divide magnitudes with the simulator operators.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    logic [31:0] ma, mb, q0, r0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      ma = (sgn && a[31]) ? 32'd0 - a : a;
      mb = (sgn && b[31]) ? 32'd0 - b : b;
      q0 = ma / mb;
      r0 = ma % mb;
      q  = (sgn && (a[31] ^ b[31])) ? 32'd0 - q0 : q0;
      r  = (sgn && a[31]) ? 32'd0 - r0 : r0;
      z  = 1'b0;
    end
  endtask

  // Monitor: pop and compare on every DONE pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_val($sformatf("quot%0d", e.id), quotient, e.q);
          check_val($sformatf("rem%0d", e.id), remainder, e.r);
          check_val($sformatf("dz%0d", e.id), 32'(div_zero), 32'(e.z));
          check_val($sformatf("lat%0d", e.id), cyc - e.start_cyc, e.lat);
        end
        check_val("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic z, input int lat);
    sb_q.push_back('{q, r, z, lat, cyc, op_id});
    op_id++;
  endtask

  task automatic wait_done(input int prev);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt != prev) got = 1'b1;
    end
    check_val("done_seen", 32'(got), 32'd1);
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input int lat, input bit chk_busy);
    int prev;
    bit busy_ok;
    bit got = 1'b0;
    @(negedge clk);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    push_exp(eq, er, ez, lat);
    prev = done_cnt;
    @(negedge clk);
    start = 1'b0;
    #1 busy_ok = busy;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt != prev) got = 1'b1;
      else busy_ok = busy_ok & busy;
    end
    check_val("done_seen", 32'(got), 32'd1);
    if (chk_busy) check_val("busy_hold", 32'(busy_ok), 32'd1);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_val({pfx, "_busy"}, 32'(busy), 32'd0);
    check_val({pfx, "_done"}, 32'(done), 32'd0);
    check_val({pfx, "_quot"}, quotient, 32'd0);
    check_val({pfx, "_rem"}, remainder, 32'd0);
    check_val({pfx, "_dz"}, 32'(div_zero), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, q, r;
    logic        z, sgn;
    int          k1, k2, snap;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    #3;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b1);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 2, 1'b0);

    // Random cases against the model
    for (int i = 0; i < 8; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      model(sgn, a, b, q, r, z);
      run_div(sgn, a, b, q, r, z, z ? 2 : 34, 1'b0);
    end

    // START while busy is ignored
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    push_exp(32'd142, 32'd6, 1'b0, 34);
    snap = done_cnt;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(snap);
    repeat (40) @(negedge clk);
    check_val("no_extra_done", done_cnt, snap + 1);

    // START held through the DONE cycle is taken immediately
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd200; divisor = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    k1 = cyc;
    push_exp(32'd22, 32'd2, 1'b0, 34);
    snap = done_cnt;
    @(negedge clk);
    dividend = 32'd81; divisor = 32'd4;
    wait_done(snap);
    @(posedge clk); #1;
    k2 = cyc;
    push_exp(32'd20, 32'd1, 1'b0, 34);
    check_val("throughput", k2 - k1, 35);
    @(negedge clk); start = 1'b0;
    wait_done(snap + 1);

    // Reset mid-iteration discards the operation
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'h0000_DEAD; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    push_exp(32'h0000_4A39, 32'd2, 1'b0, 34);
    @(negedge clk); start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    snap = done_cnt;
    #1;
    check_zero_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_val("no_done_after_rst", done_cnt, snap);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 1'b0);

    repeat (5) @(negedge clk);
    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle 32-bit integer divide controller for the MIPS execution stage, serving DIV and DIVU. Runs a restoring shift-subtract loop, one quotient bit per cycle, on a single conditional-invert adder; the subtract is invert-plus-carry-in. Handles sign pre- and post-processing, divide-by-zero and a start/busy/done handshake. The HI/LO write-back logic consumes the results.

## Interface
- WIDTH, 32, operand/result width; counter width is clog2(WIDTH)
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  request; sampled only in IDLE
- SIGNED  in  1  1 = DIV, 0 = DIVU; captured with START
- DIVIDEND  in  WIDTH  captured with START
- DIVISOR  in  WIDTH  captured with START
- BUSY  out  1  high in PREP, ITER and FIX
- DONE  out  1  one-cycle result-valid pulse
- QUOTIENT  out  WIDTH  registered; holds until next DONE
- REMAINDER  out  WIDTH  registered; holds until next DONE
- DIV_ZERO  out  1  registered; set with DONE when DIVISOR was 0

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE + START: capture operands and SIGNED, go to PREP. START in any other state is ignored.
- PREP:
  - If the divisor is 0, go to FIX with the zero flag set.
  - Otherwise load the magnitudes. For a negative SIGNED operand this is a two's-complement negate through the shared adder (invert = 1, carry-in = 1).
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear the remainder register, set count = WIDTH-1, go to ITER.
- ITER, each cycle:
  - {rem, dq} shifted left by 1.
  - Trial = shifted rem + ~|divisor| + 1, using the adder with invert = 1, on a WIDTH+1-bit result.
  - Carry-out 1: rem <= trial and quotient bit = 1. Otherwise rem keeps the shifted value and the bit = 0.
  - At count = 0 go to FIX; else decrement.
- FIX:
  - Normal path: QUOTIENT = neg_q ? -q : q and REMAINDER = neg_r ? -rem : rem, using the adder. DIV_ZERO = 0.
  - Zero path: QUOTIENT = all-ones, REMAINDER = captured dividend, DIV_ZERO = 1.
  - Assert DONE and go to IDLE.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: falls out naturally as Q = 0x80000000, R = 0. No special case.
- The adder is time-shared between the negate steps and the trial subtracts, so exactly one use per cycle. Adder invert/carry-in are driven from the state only.

## Timing
- Reset: state IDLE, BUSY = 0, DONE = 0, QUOTIENT = 0, REMAINDER = 0, DIV_ZERO = 0, counter = 0. Applies at any time, including mid-ITER; the in-flight operation is discarded and no DONE is issued.
- Normal latency, with START sampled at edge k:
  - PREP at k+1.
  - ITER edges k+2 .. k+33 (32 iterations).
  - FIX at k+34.
  - DONE high for the one cycle following edge k+34.
- Divide-by-zero latency: DONE follows edge k+2.
- BUSY rises after edge k and falls in the same cycle DONE rises.
- A START during the DONE cycle is accepted; back-to-back throughput is one divide per 35 cycles.
- Outputs change only on the FIX edge and on reset.

## Structure
- Shared package/header: state encoding constants (IDLE = 0, PREP = 1, ITER = 2, FIX = 3), WIDTH default, counter width constant.
- One sub-module, div_step, is combinational.
  - Inputs: A, B, INVERT, CIN.
  - Outputs: SUM and COUT, computed as A + (B XOR {WIDTH{INVERT}}) + CIN.
  - Instantiated once. The FSM, counter and registers live in div_sequencer.

## Test plan
- DIVU 100 / 7 -> QUOTIENT = 14, REMAINDER = 2, DIV_ZERO = 0, DONE exactly 34 cycles after the START edge, BUSY high throughout.
- DIV 0xFFFFFFF9 / 2 (−7 / 2) -> QUOTIENT = 0xFFFFFFFD, REMAINDER = 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> QUOTIENT = 0xFFFFFFFD, REMAINDER = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> QUOTIENT = 0x80000000, REMAINDER = 0. DIVU 0xFFFFFFFF / 1 -> QUOTIENT = 0xFFFFFFFF, REMAINDER = 0.
- DIVU 5 / 0 -> QUOTIENT = 0xFFFFFFFF, REMAINDER = 5, DIV_ZERO = 1, DONE 2 cycles after START.
- Second START (50 / 5) pulsed at iteration 10 is ignored: first result is unchanged. START held through the DONE cycle is accepted and the next DONE follows 34 cycles later.
- RST_N low at iteration 10 -> all outputs 0 immediately, no DONE. After release, DIVU 9 / 3 -> QUOTIENT = 3, REMAINDER = 0.
